// File: rtl/equiv_check_sched_if.sv
// Bus bundle for equiv_check_sched: run control, verdict and the stimulus /
// response pair of the dual-copy equivalence harness.
//   master : run controller + the two copies (drives start/abort/num_vec/y_1/y_2)
//   slave  : the sequencer (drives wire0..wire4 and the verdict outputs)
interface equiv_check_sched_if #(
  parameter int CNT_W = 16
) ();
  logic             start;
  logic             abort;
  logic [CNT_W-1:0] num_vec;
  logic [18:0]      wire0;
  logic [19:0]      wire1;
  logic [17:0]      wire2;
  logic [11:0]      wire3;
  logic [14:0]      wire4;
  logic [90:0]      y_1;
  logic [90:0]      y_2;
  logic             busy;
  logic             done;
  logic             pass;
  logic [CNT_W-1:0] err_cnt;
  logic [CNT_W-1:0] first_fail_idx;
  logic             first_fail_vld;

  modport slave (
    input  start, abort, num_vec, y_1, y_2,
    output wire0, wire1, wire2, wire3, wire4,
    output busy, done, pass, err_cnt, first_fail_idx, first_fail_vld
  );

  modport master (
    output start, abort, num_vec, y_1, y_2,
    input  wire0, wire1, wire2, wire3, wire4,
    input  busy, done, pass, err_cnt, first_fail_idx, first_fail_vld
  );
endinterface

// File: rtl/equiv_check_sched.sv
// Sequencer for the dual-copy equivalence harness. Drives LFSR vectors onto
// wire0..wire4 (shared by both copies), waits SETTLE cycles, compares y_1
// against y_2 and reports a pass/fail verdict with error count and the index
// of the first failing vector.
//
// Ports: clk, rst_n (synchronous, active low), bus (equiv_check_sched_if.slave):
//   start/abort/num_vec in; y_1/y_2 in; wire0..wire4 out;
//   busy/done/pass/err_cnt/first_fail_idx/first_fail_vld out.
//
// Build option: STOP_ON_FAIL_EN -- the first mismatch ends the run at once
// and the LFSR keeps the failing vector so it can be replayed.
//
// state    | meaning
// ---------+------------------------------------------------------
// S_IDLE   | waiting for start; verdict of the last run held
// S_APPLY  | current vector on wire0..wire4, first cycle
// S_SETTLE | letting both copies settle for SETTLE cycles
// S_CHECK  | compare y_1 vs y_2, advance LFSR and vector index
// S_DONE   | one-cycle done pulse, verdict valid
module equiv_check_sched #(
  parameter int          SETTLE = 2,
  parameter logic [83:0] SEED   = 84'h1,
  parameter int          CNT_W  = 16
) (
  input logic                clk,
  input logic                rst_n,
  equiv_check_sched_if.slave bus
);
  // An all-zero LFSR would lock up, so a zero seed is replaced by 1.
  localparam logic [83:0]      SEED_EFF    = (SEED == '0) ? 84'h1 : SEED;
  localparam logic [3:0]       SETTLE_LAST = (SETTLE > 0) ? 4'(SETTLE - 1) : 4'd0;
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_APPLY,
    S_SETTLE,
    S_CHECK,
    S_DONE
  } state_t;

  state_t           state, state_d;
  logic [83:0]      stim, stim_d;
  logic [83:0]      vec, vec_d;
  logic [CNT_W-1:0] num_lat, num_lat_d;
  logic [CNT_W-1:0] vec_idx, vec_idx_d;
  logic [CNT_W-1:0] err_cnt, err_cnt_d;
  logic [CNT_W-1:0] ffi, ffi_d;
  logic             ffv, ffv_d;
  logic             pass, pass_d;
  logic [3:0]       settle_cnt, settle_cnt_d;
  logic             mismatch;
  logic             stop_now;
  logic [83:0]      stim_adv;

  assign mismatch = (bus.y_1 != bus.y_2);
  // Fibonacci LFSR, taps 84 and 71.
  assign stim_adv = {stim[82:0], stim[83] ^ stim[70]};

`ifdef STOP_ON_FAIL_EN
  assign stop_now = mismatch;
`else
  assign stop_now = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      stim       <= SEED_EFF;
      vec        <= SEED_EFF;
      num_lat    <= '0;
      vec_idx    <= '0;
      err_cnt    <= '0;
      ffi        <= '0;
      ffv        <= 1'b0;
      pass       <= 1'b0;
      settle_cnt <= '0;
    end else begin
      state      <= state_d;
      stim       <= stim_d;
      vec        <= vec_d;
      num_lat    <= num_lat_d;
      vec_idx    <= vec_idx_d;
      err_cnt    <= err_cnt_d;
      ffi        <= ffi_d;
      ffv        <= ffv_d;
      pass       <= pass_d;
      settle_cnt <= settle_cnt_d;
    end
  end

  always_comb begin
    state_d      = state;
    stim_d       = stim;
    vec_d        = vec;
    num_lat_d    = num_lat;
    vec_idx_d    = vec_idx;
    err_cnt_d    = err_cnt;
    ffi_d        = ffi;
    ffv_d        = ffv;
    pass_d       = pass;
    settle_cnt_d = settle_cnt;

    if (state != S_IDLE && bus.abort) begin
      // Abort drops the run without a done pulse; counters keep their values.
      state_d = S_IDLE;
      pass_d  = 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start && !bus.abort) begin
            num_lat_d    = bus.num_vec;
            err_cnt_d    = '0;
            ffi_d        = '0;
            ffv_d        = 1'b0;
            pass_d       = 1'b0;
            vec_idx_d    = '0;
            settle_cnt_d = '0;
            if (bus.num_vec == '0) begin
              state_d = S_DONE;
              pass_d  = 1'b1;
            end else begin
              state_d = S_APPLY;
              vec_d   = stim;
            end
          end
        end
        S_APPLY: state_d = (SETTLE > 0) ? S_SETTLE : S_CHECK;
        S_SETTLE: begin
          if (settle_cnt == SETTLE_LAST) begin
            settle_cnt_d = '0;
            state_d      = S_CHECK;
          end else begin
            settle_cnt_d = settle_cnt + 4'd1;
          end
        end
        S_CHECK: begin
          if (mismatch) begin
            if (err_cnt != CNT_MAX) err_cnt_d = err_cnt + CNT_W'(1);
            if (!ffv) begin
              ffv_d = 1'b1;
              ffi_d = vec_idx;
            end
          end
          if (stop_now) begin
            // LFSR and index hold so the failing vector stays available.
            state_d = S_DONE;
            pass_d  = 1'b0;
          end else begin
            stim_d    = stim_adv;
            vec_idx_d = vec_idx + CNT_W'(1);
            if (vec_idx == num_lat - CNT_W'(1)) begin
              state_d = S_DONE;
              pass_d  = (err_cnt == '0) && !mismatch;
            end else begin
              state_d = S_APPLY;
              vec_d   = stim_adv;
            end
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign bus.wire0          = vec[18:0];
  assign bus.wire1          = vec[38:19];
  assign bus.wire2          = vec[56:39];
  assign bus.wire3          = vec[68:57];
  assign bus.wire4          = vec[83:69];
  assign bus.busy           = (state != S_IDLE);
  assign bus.done           = (state == S_DONE);
  assign bus.pass           = pass;
  assign bus.err_cnt        = err_cnt;
  assign bus.first_fail_idx = ffi;
  assign bus.first_fail_vld = ffv;
endmodule

// File: tb/tb_equiv_check_sched.sv
// Scoreboard bench for equiv_check_sched: the stimulus process predicts each
// run's verdict from an LFSR/vector-list model and queues it; the monitor
// pops and compares whenever done pulses.
module tb_equiv_check_sched;
  localparam int          CNT_W  = 16;
  localparam int          SETTLE = 2;
  localparam logic [83:0] SEED   = 84'h1;
`ifdef STOP_ON_FAIL_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  typedef struct {
    logic             pass;
    logic [CNT_W-1:0] err;
    logic [CNT_W-1:0] ffi;
    logic             ffv;
    logic [83:0]      last;
    longint           done_cyc;
  } exp_t;

  logic clk;
  logic rst_n;
  equiv_check_sched_if #(.CNT_W(CNT_W)) bus ();

  equiv_check_sched #(.SETTLE(SETTLE), .SEED(SEED), .CNT_W(CNT_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  exp_t        exp_q[$];
  logic [83:0] bad_vec[32];
  int          bad_bit[32];
  int          n_bad;
  logic [83:0] m_stim, m_wires;
  longint      cyc;
  int          n_vec, n_mis;
  logic [83:0] cur;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  assign cur = {bus.wire4, bus.wire3, bus.wire2, bus.wire1, bus.wire0};

  // The two "copies": identical unless the current vector is in the fault list.
  always_comb begin
    logic [90:0] y;
    y = {cur[6:0], cur};
    bus.y_1 = y;
    for (int i = 0; i < 32; i++)
      if (i < n_bad && bad_vec[i] == cur) y = y ^ (91'd1 << bad_bit[i]);
    bus.y_2 = y;
  end

  function automatic logic [83:0] adv(input logic [83:0] s);
    return {s[82:0], s[83] ^ s[70]};
  endfunction

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic run(input int n, input logic [31:0] badm, input bit glitch, input bit probe);
    exp_t e;
    logic [83:0] s, v1;
    int ran, nb, cnt, j, lat;
    s = m_stim; v1 = '0; ran = 0; nb = 0;
    e.pass = 1'b0; e.err = '0; e.ffi = '0; e.ffv = 1'b0; e.last = m_wires;
    for (int i = 0; i < n; i++) begin
      if (i == 1) v1 = s;
      e.last = s;
      ran = i + 1;
      if (badm[i]) begin
        bad_vec[nb] = s;
        bad_bit[nb] = int'($urandom_range(0, 90));
        nb++;
        if (e.err != '1) e.err = e.err + 1'b1;
        if (!e.ffv) begin
          e.ffv = 1'b1;
          e.ffi = CNT_W'(i);
        end
      end
      if (STOP && badm[i]) break;
      s = adv(s);
    end
    lat = ran * (2 + SETTLE) + 1;
    e.pass = (e.err == '0);
    e.done_cyc = cyc + lat;
    n_bad = nb;
    m_stim = s;
    m_wires = e.last;
    bus.num_vec = CNT_W'(n);
    bus.start = 1'b1;
    exp_q.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
    bus.num_vec = CNT_W'($urandom);
    j = 1; cnt = 0;
    while (bus.busy && cnt < 2000) begin
      cnt++;
      if (probe && n >= 2 && j == 3 + SETTLE) check("wires_after_first_check", cur, v1);
      if (glitch && j == 3) begin
        bus.start = 1'b1;
        bus.num_vec = CNT_W'($urandom);
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      j++;
    end
    bus.start = 1'b0;
    check("busy_cycles", cnt, lat);
    check("run_ended", bus.busy, 1'b0);
    @(negedge clk);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_busy"}, bus.busy, 1'b0);
    check({tag, "_done"}, bus.done, 1'b0);
    check({tag, "_pass"}, bus.pass, 1'b0);
    check({tag, "_err_cnt"}, bus.err_cnt, '0);
    check({tag, "_ffi"}, bus.first_fail_idx, '0);
    check({tag, "_ffv"}, bus.first_fail_vld, 1'b0);
    check({tag, "_wires"}, cur, SEED);
  endtask

  // Monitor: every done pulse must match the oldest predicted run.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && bus.done) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_mis++;
          $display("FAIL spurious_done: done=1 at cycle %0d, expected no pulse", cyc);
        end else begin
          e = exp_q.pop_front();
          check("done_cycle", cyc, e.done_cyc);
          check("pass", bus.pass, e.pass);
          check("err_cnt", bus.err_cnt, e.err);
          check("first_fail_vld", bus.first_fail_vld, e.ffv);
          check("first_fail_idx", bus.first_fail_idx, e.ffi);
          check("last_vector", cur, e.last);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic [83:0] v0;
    n_vec = 0; n_mis = 0; n_bad = 0;
    m_stim = SEED; m_wires = SEED;
    rst_n = 1'b0;
    bus.start = 1'b1;          // start during reset must be ignored
    bus.abort = 1'b0;
    bus.num_vec = CNT_W'(3);
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    rst_n = 1'b1;
    bus.start = 1'b0;
    @(negedge clk);
    check("idle_after_reset", bus.busy, 1'b0);

    run(4, 32'h0, 1'b0, 1'b1);           // clean run, wires 1 -> 2 after first CHECK
    run(5, 32'h4, 1'b0, 1'b0);           // mismatch on vector index 2 only
    run(0, 32'h0, 1'b0, 1'b0);           // empty run

    // Abort in SETTLE of vector 1.
    v0 = m_stim;
    n_bad = 0;
    bus.num_vec = CNT_W'(5);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    m_stim = adv(v0);
    m_wires = adv(v0);
    check("abort_busy", bus.busy, 1'b0);
    check("abort_pass", bus.pass, 1'b0);
    check("abort_err_cnt", bus.err_cnt, '0);
    check("abort_wires", cur, m_wires);
    // abort and start together in IDLE: no run
    bus.abort = 1'b1;
    bus.start = 1'b1;
    bus.num_vec = CNT_W'(2);
    @(negedge clk);
    bus.abort = 1'b0;
    bus.start = 1'b0;
    check("abort_beats_start", bus.busy, 1'b0);
    @(negedge clk);
    run(3, 32'h2, 1'b0, 1'b0);           // restart after abort is accepted

    // Reset during CHECK of vector 1 with a mismatch pending.
    n_bad = 1;
    bad_vec[0] = adv(m_stim);
    bad_bit[0] = 0;
    bus.num_vec = CNT_W'(4);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    bus.start = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    bus.start = 1'b0;
    m_stim = SEED;
    m_wires = SEED;
    check_reset_state("midrun_reset");
    @(negedge clk);
    check("start_in_reset_ignored", bus.busy, 1'b0);

    for (int r = 0; r < 12; r++) begin
      int n;
      logic [31:0] m;
      n = (r % 5 == 4) ? 0 : int'($urandom_range(1, 12));
      m = $urandom & $urandom;
      run(n, m, r[0], 1'b0);
    end

    repeat (3) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule
